obi_demux_1_to_n: RTL and testbench
===================================

OBI_DEMUX_1_TO_N -- requirements
Module: obi_demux_1_to_n

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of slave ports (2..16).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, max in-flight transactions (1..15).
REQ-003 SHALL have parameter PORT_BASE_ADDRS, default {32'h8000_0000, 32'h0000_1000, ...}, N_PORTS*32-bit packed; slice k is port k base.
REQ-004 SHALL have parameter PORT_END_ADDRS, default matching ends, N_PORTS*32-bit packed; slice k is port k inclusive end.
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, rdata returned for unmapped access.
REQ-006 SHALL have ports: clk_i in 1, clock; rst_ni in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: ctrl_req_i in 1; ctrl_gnt_o out 1; ctrl_addr_i in 32; ctrl_we_i in 1; ctrl_be_i in 4; ctrl_wdata_i in 32; ctrl_rvalid_o out 1; ctrl_rdata_o out 32.
REQ-008 SHALL have ports: port_req_o out N; port_gnt_i in N; port_addr_o out 32N; port_we_o out N; port_be_o out 4N; port_wdata_o out 32N; port_rvalid_i in N; port_rdata_i in 32N (slice k = port k).
REQ-009 SHALL have illegal_access_o out 1, high in any cycle with ctrl_req_i high to an unmapped address.

Function
REQ-010 SHALL decode sel = lowest k with base_k <= ctrl_addr_i <= end_k; sel = ERR (value N_PORTS) when none match.
REQ-011 SHALL broadcast addr/we/be/wdata to all ports unregistered.
REQ-012 SHALL hold registers cnt (0..MAX_OUTSTANDING) and tgt (0..N_PORTS).
REQ-013 SHALL compute can_issue = (cnt==0) or (sel==tgt and sel!=ERR and cnt<MAX_OUTSTANDING); target switches only when cnt==0.
REQ-014 SHALL drive port_req_o[k] = ctrl_req_i and sel==k and can_issue; all others 0.
REQ-015 SHALL drive ctrl_gnt_o = can_issue and (sel==ERR ? 1 : port_gnt_i[sel]), zero-latency combinational.
REQ-016 SHALL count reads and writes alike; accept = ctrl_req_i and ctrl_gnt_o; tgt <= sel on accept.
REQ-017 SHALL drive ctrl_rvalid_o = cnt>0 and (tgt==ERR ? 1 : port_rvalid_i[tgt]); unmapped response appears exactly one cycle after its grant.
REQ-018 SHALL drive ctrl_rdata_o = port_rdata_i[tgt] for mapped tgt, ERR_RDATA when tgt==ERR.
REQ-019 SHALL update cnt <= cnt + accept - ctrl_rvalid_o; simultaneous accept and response leaves cnt unchanged.
REQ-020 SHALL block grant when cnt==MAX_OUTSTANDING even if a response retires that cycle.
REQ-021 SHALL ignore rvalid from any port != tgt, or while cnt==0, without forwarding or counting.

Reset
REQ-022 SHALL on rst_ni low asynchronously set cnt=0, tgt=ERR; ctrl_rvalid_o=0 and all port_req_o=0 while ctrl_req_i=0.
REQ-023 SHALL discard in-flight transactions on reset mid-operation; late slave rvalid after reset is ignored per REQ-021.

Configuration
REQ-024 SHALL with OBI_DEMUX_ERR_RESP_EN defined add output ctrl_err_o (1 bit) = ctrl_rvalid_o and tgt==ERR.
REQ-025 SHALL without OBI_DEMUX_ERR_RESP_EN omit ctrl_err_o; unmapped accesses still granted and answered with ERR_RDATA.

Structure
REQ-026 SHALL take OBI_ADDR_W=32, OBI_DATA_W=32, OBI_BE_W=4 and default ERR_RDATA from shared package obi_pkg.
REQ-027 SHALL place decoding in combinational sub-module obi_addr_decoder (inputs addr, windows; outputs sel, hit).

Verification
REQ-028 SHALL cover: 4 back-to-back reads to port1 (0x1000..0x100C), gnt=1, rvalid latency 2 -> four grants in consecutive cycles, cnt peaks 2, rdata in order.
REQ-029 SHALL cover: MAX_OUTSTANDING=2, port0 never rvalid, 3 reads -> third req held, ctrl_gnt_o=0 until one rvalid, then granted the following cycle.
REQ-030 SHALL cover: read port1 outstanding, then req to port0 -> port_req_o[0]=0, gnt=0 until port1 rvalid; then granted.
REQ-031 SHALL cover: read 0x4000_0000 (unmapped) -> gnt same cycle, illegal_access_o=1, next cycle rvalid=1, rdata=0xDEADBEEF, ctrl_err_o=1 when macro defined.
REQ-032 SHALL cover: spurious port_rvalid_i[2] with cnt==0 -> ctrl_rvalid_o stays 0; rst_ni low with cnt=3 -> cnt=0 immediately, no rvalid forwarded.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared OBI bus widths and the default read data returned for unmapped accesses.
package obi_pkg;

   localparam int OBI_ADDR_W = 32;
   localparam int OBI_DATA_W = 32;
   localparam int OBI_BE_W   = 4;

   localparam logic [OBI_DATA_W-1:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_addr_decoder.sv
// Combinational address window decoder: the lowest-numbered matching window wins,
// and sel reports N_PORTS when no window matches.
module obi_addr_decoder
   import obi_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int SEL_W   = $clog2(N_PORTS + 1)
) (
   input  logic [OBI_ADDR_W-1:0]         addr,
   input  logic [N_PORTS*OBI_ADDR_W-1:0] base_addrs,
   input  logic [N_PORTS*OBI_ADDR_W-1:0] end_addrs,
   output logic [SEL_W-1:0]              sel,
   output logic                          hit
);

   // Scanning downwards lets the lowest matching index overwrite any higher one.
   always_comb begin
      sel = SEL_W'(N_PORTS);
      hit = 1'b0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         if ((addr >= base_addrs[k*OBI_ADDR_W +: OBI_ADDR_W]) &&
             (addr <= end_addrs[k*OBI_ADDR_W +: OBI_ADDR_W])) begin
            sel = SEL_W'(k);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/obi_demux_1_to_n.sv
// OBI 1-to-N demultiplexer with in-order outstanding tracking and an internal error slave.
// Define OBI_DEMUX_ERR_RESP_EN to add the ctrl_err_o response flag.
module obi_demux_1_to_n
   import obi_pkg::*;
#(
   parameter int N_PORTS         = 4,
   parameter int MAX_OUTSTANDING = 4,
   // Slice k (k*32 upwards) belongs to port k; port 0 is the least-significant slice.
   parameter logic [N_PORTS*OBI_ADDR_W-1:0] PORT_BASE_ADDRS =
      {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h8000_0000},
   parameter logic [N_PORTS*OBI_ADDR_W-1:0] PORT_END_ADDRS  =
      {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h8FFF_FFFF},
   parameter logic [OBI_DATA_W-1:0] ERR_RDATA = OBI_ERR_RDATA
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,

   input  logic                          ctrl_req_i,
   output logic                          ctrl_gnt_o,
   input  logic [OBI_ADDR_W-1:0]         ctrl_addr_i,
   input  logic                          ctrl_we_i,
   input  logic [OBI_BE_W-1:0]           ctrl_be_i,
   input  logic [OBI_DATA_W-1:0]         ctrl_wdata_i,
   output logic                          ctrl_rvalid_o,
   output logic [OBI_DATA_W-1:0]         ctrl_rdata_o,

   output logic [N_PORTS-1:0]            port_req_o,
   input  logic [N_PORTS-1:0]            port_gnt_i,
   output logic [N_PORTS*OBI_ADDR_W-1:0] port_addr_o,
   output logic [N_PORTS-1:0]            port_we_o,
   output logic [N_PORTS*OBI_BE_W-1:0]   port_be_o,
   output logic [N_PORTS*OBI_DATA_W-1:0] port_wdata_o,
   input  logic [N_PORTS-1:0]            port_rvalid_i,
   input  logic [N_PORTS*OBI_DATA_W-1:0] port_rdata_i,

`ifdef OBI_DEMUX_ERR_RESP_EN
   output logic                          ctrl_err_o,
`endif
   output logic                          illegal_access_o
);

   localparam int SEL_W = $clog2(N_PORTS + 1);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(N_PORTS);

   logic [SEL_W-1:0] sel;
   logic             hit;
   logic [SEL_W-1:0] tgt;
   logic [CNT_W-1:0] cnt;
   logic             can_issue;
   logic             sel_gnt;
   logic             tgt_rvalid;
   logic             accept;

   obi_addr_decoder #(
      .N_PORTS (N_PORTS),
      .SEL_W   (SEL_W)
   ) u_decoder (
      .addr       (ctrl_addr_i),
      .base_addrs (PORT_BASE_ADDRS),
      .end_addrs  (PORT_END_ADDRS),
      .sel        (sel),
      .hit        (hit)
   );

   assign port_addr_o  = {N_PORTS{ctrl_addr_i}};
   assign port_we_o    = {N_PORTS{ctrl_we_i}};
   assign port_be_o    = {N_PORTS{ctrl_be_i}};
   assign port_wdata_o = {N_PORTS{ctrl_wdata_i}};

   // Responses come back in order, so a new target is only allowed once the pipe has drained.
   assign can_issue = (cnt == '0) ||
                      ((sel == tgt) && hit && (cnt < CNT_W'(MAX_OUTSTANDING)));

   always_comb begin
      sel_gnt    = 1'b1;
      port_req_o = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_gnt       = port_gnt_i[k];
            port_req_o[k] = ctrl_req_i && can_issue;
         end
      end
   end

   assign ctrl_gnt_o       = can_issue && sel_gnt;
   assign accept           = ctrl_req_i && ctrl_gnt_o;
   assign illegal_access_o = ctrl_req_i && !hit;

   // The error slave answers immediately; mapped targets forward the slave's response.
   always_comb begin
      tgt_rvalid   = (tgt == ERR_SEL);
      ctrl_rdata_o = ERR_RDATA;
      for (int k = 0; k < N_PORTS; k++) begin
         if (tgt == SEL_W'(k)) begin
            tgt_rvalid   = port_rvalid_i[k];
            ctrl_rdata_o = port_rdata_i[k*OBI_DATA_W +: OBI_DATA_W];
         end
      end
   end

   assign ctrl_rvalid_o = (cnt != '0) && tgt_rvalid;

`ifdef OBI_DEMUX_ERR_RESP_EN
   assign ctrl_err_o = ctrl_rvalid_o && (tgt == ERR_SEL);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
         tgt <= ERR_SEL;
      end else begin
         cnt <= cnt + CNT_W'(accept) - CNT_W'(ctrl_rvalid_o);
         if (accept) begin
            tgt <= sel;
         end
      end
   end

endmodule

// File: tb/tb_obi_demux_1_to_n.sv
// Directed bench for obi_demux_1_to_n: one default instance and one with two outstanding slots.
module tb_obi_demux_1_to_n;

   logic         clk;
   logic         rst_n;
   logic         ctrl_req;
   logic [31:0]  ctrl_addr;
   logic         ctrl_we;
   logic [3:0]   ctrl_be;
   logic [31:0]  ctrl_wdata;
   logic [3:0]   port_gnt;
   logic [3:0]   port_rvalid;
   logic [127:0] port_rdata;

   logic         a_gnt, a_rvalid, a_illegal;
   logic [31:0]  a_rdata;
   logic [3:0]   a_port_req, a_port_we;
   logic [127:0] a_port_addr, a_port_wdata;
   logic [15:0]  a_port_be;

   logic         b_gnt, b_rvalid, b_illegal;
   logic [31:0]  b_rdata;
   logic [3:0]   b_port_req, b_port_we;
   logic [127:0] b_port_addr, b_port_wdata;
   logic [15:0]  b_port_be;

`ifdef OBI_DEMUX_ERR_RESP_EN
   logic         a_err, b_err;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   obi_demux_1_to_n dut_a (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .ctrl_req_i       (ctrl_req),
      .ctrl_gnt_o       (a_gnt),
      .ctrl_addr_i      (ctrl_addr),
      .ctrl_we_i        (ctrl_we),
      .ctrl_be_i        (ctrl_be),
      .ctrl_wdata_i     (ctrl_wdata),
      .ctrl_rvalid_o    (a_rvalid),
      .ctrl_rdata_o     (a_rdata),
      .port_req_o       (a_port_req),
      .port_gnt_i       (port_gnt),
      .port_addr_o      (a_port_addr),
      .port_we_o        (a_port_we),
      .port_be_o        (a_port_be),
      .port_wdata_o     (a_port_wdata),
      .port_rvalid_i    (port_rvalid),
      .port_rdata_i     (port_rdata),
`ifdef OBI_DEMUX_ERR_RESP_EN
      .ctrl_err_o       (a_err),
`endif
      .illegal_access_o (a_illegal)
   );

   obi_demux_1_to_n #(
      .MAX_OUTSTANDING (2)
   ) dut_b (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .ctrl_req_i       (ctrl_req),
      .ctrl_gnt_o       (b_gnt),
      .ctrl_addr_i      (ctrl_addr),
      .ctrl_we_i        (ctrl_we),
      .ctrl_be_i        (ctrl_be),
      .ctrl_wdata_i     (ctrl_wdata),
      .ctrl_rvalid_o    (b_rvalid),
      .ctrl_rdata_o     (b_rdata),
      .port_req_o       (b_port_req),
      .port_gnt_i       (port_gnt),
      .port_addr_o      (b_port_addr),
      .port_we_o        (b_port_we),
      .port_be_o        (b_port_be),
      .port_wdata_o     (b_port_wdata),
      .port_rvalid_i    (port_rvalid),
      .port_rdata_i     (port_rdata),
`ifdef OBI_DEMUX_ERR_RESP_EN
      .ctrl_err_o       (b_err),
`endif
      .illegal_access_o (b_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Moves one cycle forward, drives the inputs just after the edge and lets logic settle.
   // Port k returns rdata with k in the top nibble so the selected slave is identifiable.
   task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic we,
                                input logic [3:0] rvalid, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      ctrl_req    = req;
      ctrl_addr   = addr;
      ctrl_we     = we;
      port_rvalid = rvalid;
      port_rdata  = {rdata | 32'h3000_0000, rdata | 32'h2000_0000,
                     rdata | 32'h1000_0000, rdata};
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      ctrl_req    = 1'b0;
      ctrl_addr   = 32'h0;
      ctrl_we     = 1'b0;
      ctrl_be     = 4'hF;
      ctrl_wdata  = 32'h0;
      port_gnt    = 4'b1111;
      port_rvalid = 4'b0000;
      port_rdata  = '0;

      #2;
      checkOutput("reset_rvalid", {31'h0, a_rvalid}, 32'h0);
      checkOutput("reset_port_req", {28'h0, a_port_req}, 32'h0);
      checkOutput("reset_cnt", 32'(dut_a.cnt), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Four back-to-back reads to port 1, slave latency 2.
      applyStimulus(1'b1, 32'h0000_1000, 1'b0, 4'b0000, 32'h0);
      checkOutput("b2b_gnt0", {31'h0, a_gnt}, 32'h1);
      checkOutput("b2b_req0", {28'h0, a_port_req}, 32'h2);
      checkOutput("b2b_cnt0", 32'(dut_a.cnt), 32'h0);
      checkOutput("b2b_addr_bcast", a_port_addr[95:64], 32'h0000_1000);
      applyStimulus(1'b1, 32'h0000_1004, 1'b0, 4'b0000, 32'h0);
      checkOutput("b2b_gnt1", {31'h0, a_gnt}, 32'h1);
      checkOutput("b2b_rvalid1", {31'h0, a_rvalid}, 32'h0);
      checkOutput("b2b_cnt1", 32'(dut_a.cnt), 32'h1);
      applyStimulus(1'b1, 32'h0000_1008, 1'b0, 4'b0010, 32'h0000_A000);
      checkOutput("b2b_gnt2", {31'h0, a_gnt}, 32'h1);
      checkOutput("b2b_rvalid2", {31'h0, a_rvalid}, 32'h1);
      checkOutput("b2b_rdata2", a_rdata, 32'h1000_A000);
      checkOutput("b2b_cnt2", 32'(dut_a.cnt), 32'h2);
      applyStimulus(1'b1, 32'h0000_100C, 1'b0, 4'b0010, 32'h0000_A001);
      checkOutput("b2b_gnt3", {31'h0, a_gnt}, 32'h1);
      checkOutput("b2b_req3", {28'h0, a_port_req}, 32'h2);
      checkOutput("b2b_rdata3", a_rdata, 32'h1000_A001);
      checkOutput("b2b_cnt3", 32'(dut_a.cnt), 32'h2);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0010, 32'h0000_A002);
      checkOutput("b2b_rdata4", a_rdata, 32'h1000_A002);
      checkOutput("b2b_cnt4", 32'(dut_a.cnt), 32'h2);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0010, 32'h0000_A003);
      checkOutput("b2b_rvalid5", {31'h0, a_rvalid}, 32'h1);
      checkOutput("b2b_rdata5", a_rdata, 32'h1000_A003);
      checkOutput("b2b_cnt5", 32'(dut_a.cnt), 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
      checkOutput("b2b_rvalid6", {31'h0, a_rvalid}, 32'h0);
      checkOutput("b2b_cnt6", 32'(dut_a.cnt), 32'h0);

      // Write to port 1 outstanding, then a request to port 0 must wait for it.
      ctrl_wdata = 32'h1234_5678;
      applyStimulus(1'b1, 32'h0000_1010, 1'b1, 4'b0000, 32'h0);
      checkOutput("sw_wr_gnt", {31'h0, a_gnt}, 32'h1);
      checkOutput("sw_we_bcast", {28'h0, a_port_we}, 32'hF);
      checkOutput("sw_wdata_bcast", a_port_wdata[63:32], 32'h1234_5678);
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
      checkOutput("sw_blk_gnt", {31'h0, a_gnt}, 32'h0);
      checkOutput("sw_blk_req", {28'h0, a_port_req}, 32'h0);
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
      checkOutput("sw_blk_gnt2", {31'h0, a_gnt}, 32'h0);
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'b0010, 32'h0000_B000);
      checkOutput("sw_rsp_rvalid", {31'h0, a_rvalid}, 32'h1);
      checkOutput("sw_rsp_rdata", a_rdata, 32'h1000_B000);
      checkOutput("sw_rsp_gnt", {31'h0, a_gnt}, 32'h0);
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
      checkOutput("sw_new_gnt", {31'h0, a_gnt}, 32'h1);
      checkOutput("sw_new_req", {28'h0, a_port_req}, 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0101, 32'h0000_C000);
      checkOutput("p0_rvalid", {31'h0, a_rvalid}, 32'h1);
      checkOutput("p0_rdata", a_rdata, 32'h0000_C000);

      // A response with nothing outstanding must be dropped.
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0100, 32'h0000_C001);
      checkOutput("spur_rvalid", {31'h0, a_rvalid}, 32'h0);

      // Unmapped read: granted at once, answered by the error slave next cycle.
      applyStimulus(1'b1, 32'h4000_0000, 1'b0, 4'b0000, 32'h0000_D000);
      checkOutput("spur_cnt", 32'(dut_a.cnt), 32'h0);
      checkOutput("err_gnt", {31'h0, a_gnt}, 32'h1);
      checkOutput("err_illegal", {31'h0, a_illegal}, 32'h1);
      checkOutput("err_req", {28'h0, a_port_req}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0000_D000);
      checkOutput("err_rvalid", {31'h0, a_rvalid}, 32'h1);
      checkOutput("err_rdata", a_rdata, 32'hDEAD_BEEF);
      checkOutput("err_illegal_idle", {31'h0, a_illegal}, 32'h0);
`ifdef OBI_DEMUX_ERR_RESP_EN
      checkOutput("err_flag", {31'h0, a_err}, 32'h1);
`endif
      applyStimulus(1'b1, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
      checkOutput("err_done_rvalid", {31'h0, a_rvalid}, 32'h0);
      checkOutput("p2_gnt0", {31'h0, a_gnt}, 32'h1);

      // Build up three outstanding reads to port 2, then reset mid-flight.
      applyStimulus(1'b1, 32'h0000_2004, 1'b0, 4'b0000, 32'h0);
      applyStimulus(1'b1, 32'h0000_2008, 1'b0, 4'b0000, 32'h0);
      checkOutput("p2_gnt2", {31'h0, a_gnt}, 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
      checkOutput("rst_cnt_before", 32'(dut_a.cnt), 32'h3);
      port_rvalid = 4'b0100;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_cnt_async", 32'(dut_a.cnt), 32'h0);
      checkOutput("rst_rvalid", {31'h0, a_rvalid}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("rst_late_rvalid", {31'h0, a_rvalid}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0100, 32'h0);
      checkOutput("rst_late_cnt", 32'(dut_a.cnt), 32'h0);

      // Two-slot instance: third read to a silent port 0 waits for a response.
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0);
      checkOutput("lim_gnt0", {31'h0, b_gnt}, 32'h1);
      applyStimulus(1'b1, 32'h8000_0004, 1'b0, 4'b0000, 32'h0);
      checkOutput("lim_gnt1", {31'h0, b_gnt}, 32'h1);
      applyStimulus(1'b1, 32'h8000_0008, 1'b0, 4'b0000, 32'h0);
      checkOutput("lim_held_gnt", {31'h0, b_gnt}, 32'h0);
      checkOutput("lim_held_req", {28'h0, b_port_req}, 32'h0);
      applyStimulus(1'b1, 32'h8000_0008, 1'b0, 4'b0000, 32'h0);
      checkOutput("lim_held_gnt2", {31'h0, b_gnt}, 32'h0);
      applyStimulus(1'b1, 32'h8000_0008, 1'b0, 4'b0001, 32'h0000_E000);
      checkOutput("lim_rsp_rvalid", {31'h0, b_rvalid}, 32'h1);
      checkOutput("lim_rsp_gnt", {31'h0, b_gnt}, 32'h0);
      applyStimulus(1'b1, 32'h8000_0008, 1'b0, 4'b0000, 32'h0);
      checkOutput("lim_after_gnt", {31'h0, b_gnt}, 32'h1);
      checkOutput("lim_after_req", {28'h0, b_port_req}, 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
      checkOutput("lim_cnt", 32'(dut_b.cnt), 32'h2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
